// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack handshake, ID-stage outputs and control inputs.
// Optional perf-counter signals exist only when IF_PERF_CNT_EN is defined.
interface if_fetch_unit_if #(
    parameter int PC_W = 64
);
    logic            p_IMEM_Req;
    logic [PC_W-1:0] p_IMEM_Addr;
    logic            p_IMEM_Ack;
    logic [31:0]     p_IMEM_Data;
    logic            p_Stall;
    logic            p_Redirect;
    logic [PC_W-1:0] p_Redirect_PC;
    logic [31:0]     p_ID_IN_Instruction;
    logic            p_ID_Valid;
    logic [PC_W-1:0] p_ID_PC;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     p_Fetch_Count;
    logic [31:0]     p_Redirect_Count;
`endif

    modport master (
        output p_IMEM_Req, p_IMEM_Addr, p_ID_IN_Instruction, p_ID_Valid, p_ID_PC,
        input  p_IMEM_Ack, p_IMEM_Data, p_Stall, p_Redirect, p_Redirect_PC
`ifdef IF_PERF_CNT_EN
        , output p_Fetch_Count, p_Redirect_Count
`endif
    );

    modport slave (
        input  p_IMEM_Req, p_IMEM_Addr, p_ID_IN_Instruction, p_ID_Valid, p_ID_PC,
        output p_IMEM_Ack, p_IMEM_Data, p_Stall, p_Redirect, p_Redirect_PC
`ifdef IF_PERF_CNT_EN
        , input p_Fetch_Count, p_Redirect_Count
`endif
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, single-outstanding IMEM fetch, one-entry stall buffer, redirect flush.
// Define IF_PERF_CNT_EN to add delivered-instruction and redirect counters.
module if_fetch_unit #(
    parameter int              PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0
) (
    input  logic          p_clk,
    input  logic          p_reset,
    if_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_drain_addr, w_drain_addr_nxt;
    logic [31:0]     r_out_instr, w_out_instr_nxt;
    logic [PC_W-1:0] r_out_pc, w_out_pc_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [31:0]     r_pend_instr, w_pend_instr_nxt;
    logic [PC_W-1:0] r_pend_pc, w_pend_pc_nxt;
    logic            r_pend_valid, w_pend_valid_nxt;

    logic [PC_W-1:0] w_addr;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_redir_pc;

    // While draining, the abandoned request keeps its original address until its ack returns.
    assign w_addr     = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign w_pc_inc   = r_pc + PC_W'(4);
    assign w_redir_pc = bus.p_Redirect_PC & ALIGN_MASK;

    assign bus.p_IMEM_Req          = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign bus.p_IMEM_Addr         = w_addr;
    assign bus.p_ID_IN_Instruction = r_out_instr;
    assign bus.p_ID_Valid          = r_out_valid;
    assign bus.p_ID_PC             = r_out_pc;

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC & ALIGN_MASK;
            r_drain_addr <= '0;
            r_out_instr  <= NOP_INSTR;
            r_out_pc     <= '0;
            r_out_valid  <= 1'b0;
            r_pend_instr <= '0;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_pend_instr <= w_pend_instr_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_out_instr_nxt  = r_out_instr;
        w_out_pc_nxt     = r_out_pc;
        w_out_valid_nxt  = r_out_valid;
        w_pend_instr_nxt = r_pend_instr;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_valid_nxt = r_pend_valid;

        if (bus.p_Redirect) begin
            // Redirect wins over stall and over any data returned this cycle.
            w_pc_nxt         = w_redir_pc;
            w_out_valid_nxt  = 1'b0;
            w_out_instr_nxt  = NOP_INSTR;
            w_pend_valid_nxt = 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus.p_IMEM_Ack) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end
                S_DRAIN: begin
                    if (bus.p_IMEM_Ack) w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_FETCH;
                S_FETCH: begin
                    if (bus.p_IMEM_Ack) begin
                        w_pc_nxt = w_pc_inc;
                        if (bus.p_Stall) begin
                            w_pend_instr_nxt = bus.p_IMEM_Data;
                            w_pend_pc_nxt    = r_pc;
                            w_pend_valid_nxt = 1'b1;
                            w_state_nxt      = S_HOLD;
                        end else begin
                            w_out_instr_nxt = bus.p_IMEM_Data;
                            w_out_pc_nxt    = r_pc;
                            w_out_valid_nxt = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.p_Stall) begin
                        w_out_instr_nxt  = r_pend_instr;
                        w_out_pc_nxt     = r_pend_pc;
                        w_out_valid_nxt  = r_pend_valid;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.p_IMEM_Ack) w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redir_cnt;
    logic        w_load;

    // An instruction is delivered when a valid word enters the output register.
    assign w_load = !bus.p_Redirect && !bus.p_Stall &&
                    (((r_state == S_FETCH) && bus.p_IMEM_Ack) ||
                     ((r_state == S_HOLD) && r_pend_valid));

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_fetch_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_load)         r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (bus.p_Redirect) r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign bus.p_Fetch_Count    = r_fetch_cnt;
    assign bus.p_Redirect_Count = r_redir_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, sequential fetch, stall/hold, redirect drain, wrap, reset pulse.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch_unit_if #(.PC_W(64)) bus();

    if_fetch_unit #(.PC_W(64), .RESET_PC(64'h100), .NOP_INSTR(NOP)) dut (
        .p_clk   (clk),
        .p_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {Req, Addr, Valid, ID_PC, Instruction}
    logic [161:0] obs;
    assign obs = {bus.p_IMEM_Req, bus.p_IMEM_Addr, bus.p_ID_Valid, bus.p_ID_PC, bus.p_ID_IN_Instruction};

    function automatic logic [31:0] dat(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic step(input logic ack, input logic [31:0] data, input logic stall,
                        input logic redir, input logic [63:0] rpc);
        bus.p_IMEM_Ack    = ack;
        bus.p_IMEM_Data   = data;
        bus.p_Stall       = stall;
        bus.p_Redirect    = redir;
        bus.p_Redirect_PC = rpc;
        @(posedge clk);
        #1;
        bus.p_IMEM_Ack  = 1'b0;
        bus.p_Stall     = 1'b0;
        bus.p_Redirect  = 1'b0;
    endtask

    task automatic test_reset;
        logic [161:0] exp;
        bus.p_IMEM_Ack = 0; bus.p_IMEM_Data = 0; bus.p_Stall = 0;
        bus.p_Redirect = 0; bus.p_Redirect_PC = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp = {1'b0, 64'h100, 1'b0, 64'h0, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_state got %h want %h", obs, exp); end
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        exp = {1'b1, 64'h100, 1'b0, 64'h0, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL idle_to_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_fetch_seq;
        logic [161:0] exp;
        for (int k = 0; k < 2; k++) begin
            logic [63:0] a;
            a = 64'h100 + 64'(4 * k);
            step(1, dat(a), 0, 0, 0);
            exp = {1'b1, a + 64'h4, 1'b1, a, dat(a)};
            total++; if (obs !== exp) begin bad++; $display("FAIL seq_ack%0d got %h want %h", k, obs, exp); end
            step(0, 0, 0, 0, 0);
            total++; if (obs !== exp) begin bad++; $display("FAIL seq_wait%0d got %h want %h", k, obs, exp); end
        end
    endtask

    task automatic test_stall;
        logic [161:0] exp;
        step(0, 0, 1, 0, 0);
        exp = {1'b1, 64'h108, 1'b1, 64'h104, dat(64'h104)};
        total++; if (obs !== exp) begin bad++; $display("FAIL stall_noack got %h want %h", obs, exp); end
        step(1, dat(64'h108), 1, 0, 0);
        exp = {1'b0, 64'h10C, 1'b1, 64'h104, dat(64'h104)};
        total++; if (obs !== exp) begin bad++; $display("FAIL stall_ack_hold got %h want %h", obs, exp); end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0);
            total++; if (obs !== exp) begin bad++; $display("FAIL hold%0d got %h want %h", k, obs, exp); end
        end
        step(0, 0, 0, 0, 0);
        exp = {1'b1, 64'h10C, 1'b1, 64'h108, dat(64'h108)};
        total++; if (obs !== exp) begin bad++; $display("FAIL hold_release got %h want %h", obs, exp); end
    endtask

    task automatic test_redirect_drain;
        logic [161:0] exp;
        step(1, dat(64'h10C), 0, 0, 0);
        exp = {1'b1, 64'h110, 1'b1, 64'h10C, dat(64'h10C)};
        total++; if (obs !== exp) begin bad++; $display("FAIL pre_redirect got %h want %h", obs, exp); end
        step(0, 0, 0, 1, 64'h2003);
        exp = {1'b1, 64'h110, 1'b0, 64'h10C, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL drain_enter got %h want %h", obs, exp); end
        step(0, 0, 0, 0, 0);
        total++; if (obs !== exp) begin bad++; $display("FAIL drain_wait got %h want %h", obs, exp); end
        step(1, 32'hDEAD_BEEF, 0, 0, 0);
        exp = {1'b1, 64'h2000, 1'b0, 64'h10C, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL drain_drop got %h want %h", obs, exp); end
        step(1, dat(64'h2000), 0, 0, 0);
        exp = {1'b1, 64'h2004, 1'b1, 64'h2000, dat(64'h2000)};
        total++; if (obs !== exp) begin bad++; $display("FAIL target_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_redirect_ack_stall;
        logic [161:0] exp;
        step(1, dat(64'h2004), 1, 1, 64'h3000);
        exp = {1'b1, 64'h3000, 1'b0, 64'h2000, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL redir_ack_stall got %h want %h", obs, exp); end
        step(0, 0, 0, 0, 0);
        total++; if (obs !== exp) begin bad++; $display("FAIL no_pending got %h want %h", obs, exp); end
        step(1, dat(64'h3000), 0, 0, 0);
        exp = {1'b1, 64'h3004, 1'b1, 64'h3000, dat(64'h3000)};
        total++; if (obs !== exp) begin bad++; $display("FAIL after_redir got %h want %h", obs, exp); end
    endtask

    task automatic test_wrap;
        logic [161:0] exp;
        step(1, dat(64'h3004), 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        exp = {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h3000, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_redirect got %h want %h", obs, exp); end
        step(1, 32'h7777_0001, 0, 0, 0);
        exp = {1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0001};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_mid;
        logic [161:0] exp;
        step(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        exp = {1'b0, 64'h100, 1'b0, 64'h0, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL async_reset got %h want %h", obs, exp); end
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 0, 0, 0);
        exp = {1'b1, 64'h100, 1'b0, 64'h0, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL post_reset_fetch got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back;
        logic [161:0] exp;
        for (int k = 0; k < 10; k++) begin
            logic [63:0] a;
            a = 64'h100 + 64'(4 * k);
            step(1, dat(a), 0, 0, 0);
            exp = {1'b1, a + 64'h4, 1'b1, a, dat(a)};
            total++; if (obs !== exp) begin bad++; $display("FAIL b2b%0d got %h want %h", k, obs, exp); end
        end
        step(0, 0, 0, 1, 64'h400);
        exp = {1'b1, 64'h128, 1'b0, 64'h124, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL redir1 got %h want %h", obs, exp); end
        step(1, 32'hBAD0_0000, 0, 1, 64'h500);
        exp = {1'b1, 64'h500, 1'b0, 64'h124, NOP};
        total++; if (obs !== exp) begin bad++; $display("FAIL redir2 got %h want %h", obs, exp); end
`ifdef IF_PERF_CNT_EN
        total++; if (bus.p_Fetch_Count !== 32'd10) begin
            bad++; $display("FAIL fetch_count got %0d want 10", bus.p_Fetch_Count);
        end
        total++; if (bus.p_Redirect_Count !== 32'd2) begin
            bad++; $display("FAIL redirect_count got %0d want 2", bus.p_Redirect_Count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_drain();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
